control_unit: RTL and testbench

//  Hardwired sequencer that drives every datapath control strobe the hand-written datapath benches drive today.

---
 rtl/control_unit_if.sv | 30 +++
 rtl/control_unit.sv | 183 ++++++++++++++++++
 tb/tb_control_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Strobe bundle between the hardwired sequencer and the datapath.
// The sequencer owns every strobe; the datapath owns the IR contents.
interface control_unit_if #(
    parameter int IR_W     = 32,
    parameter int ALU_OP_W = 4
);
    logic [IR_W-1:0]     ir;
    logic                gra, grb, grc;
    logic                r_in, r_out, ba_out;
    logic                pc_in, pc_out, inc_pc;
    logic                ir_in, y_in, z_in, z_low_out, c_out;
    logic                mar_in, mdr_in, mdr_out;
    logic                read, write, outport_in;
    logic [ALU_OP_W-1:0] alu_op;
    logic                run, done;

    modport master (
        input  ir,
        output gra, grb, grc, r_in, r_out, ba_out, pc_in, pc_out, inc_pc,
               ir_in, y_in, z_in, z_low_out, c_out, mar_in, mdr_in, mdr_out,
               read, write, outport_in, alu_op, run, done
    );

    modport slave (
        output ir,
        input  gra, grb, grc, r_in, r_out, ba_out, pc_in, pc_out, inc_pc,
               ir_in, y_in, z_in, z_low_out, c_out, mar_in, mdr_in, mdr_out,
               read, write, outport_in, alu_op, run, done
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer: one step per clock, strobes decoded from the step
// and, during execute, from the IR opcode.
//
// state  | meaning
// S_RST  | reset / first cycle after release, all strobes low, run high
// S_T0   | fetch: PC -> MAR, Z <= PC + 1
// S_T1   | fetch: Z -> PC, memory -> MDR
// S_T2   | fetch: MDR -> IR
// S_T3.. | execute steps, opcode specific; the step asserting done returns to S_T0
// S_T7   |
// S_HALT | stopped, all strobes low, run low, left only through reset_n
module control_unit #(
    parameter int IR_W     = 32,
    parameter int ALU_OP_W = 4
) (
    input logic            clk,
    input logic            reset_n,
    control_unit_if.master cu
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SHR = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_SHL = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_ROR = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_ROL = ALU_OP_W'(7);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t              state;
    logic [4:0]          opcode;
    logic [ALU_OP_W-1:0] alu_sel;
    logic                is_imm;
    logic                step_done;
    logic                to_halt;
    logic                unused_ir;

    assign opcode    = cu.ir[IR_W-1 -: 5];
    assign unused_ir = ^cu.ir[IR_W-6:0];
    assign is_imm    = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign cu.done   = step_done;

    always_comb begin
        case (opcode)
            OP_SUB:          alu_sel = ALU_SUB;
            OP_AND, OP_ANDI: alu_sel = ALU_AND;
            OP_OR, OP_ORI:   alu_sel = ALU_OR;
            OP_SHR:          alu_sel = ALU_SHR;
            OP_SHL:          alu_sel = ALU_SHL;
            OP_ROR:          alu_sel = ALU_ROR;
            OP_ROL:          alu_sel = ALU_ROL;
            default:         alu_sel = ALU_ADD;
        endcase
    end

    always_comb begin
        cu.gra = 1'b0;       cu.grb = 1'b0;        cu.grc = 1'b0;
        cu.r_in = 1'b0;      cu.r_out = 1'b0;      cu.ba_out = 1'b0;
        cu.pc_in = 1'b0;     cu.pc_out = 1'b0;     cu.inc_pc = 1'b0;
        cu.ir_in = 1'b0;     cu.y_in = 1'b0;       cu.z_in = 1'b0;
        cu.z_low_out = 1'b0; cu.c_out = 1'b0;      cu.mar_in = 1'b0;
        cu.mdr_in = 1'b0;    cu.mdr_out = 1'b0;    cu.read = 1'b0;
        cu.write = 1'b0;     cu.outport_in = 1'b0;
        cu.alu_op = ALU_ADD;
        cu.run    = 1'b1;
        step_done = 1'b0;
        to_halt   = 1'b0;
        case (state)
            S_RST: cu.alu_op = '0;
            S_HALT: begin
                cu.run    = 1'b0;
                cu.alu_op = '0;
            end
            S_T0: begin
                cu.pc_out = 1'b1; cu.mar_in = 1'b1; cu.inc_pc = 1'b1; cu.z_in = 1'b1;
            end
            S_T1: begin
                cu.z_low_out = 1'b1; cu.pc_in = 1'b1; cu.read = 1'b1; cu.mdr_in = 1'b1;
            end
            S_T2: begin
                cu.mdr_out = 1'b1; cu.ir_in = 1'b1;
            end
            default: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            S_T3: begin cu.grb = 1'b1; cu.ba_out = 1'b1; cu.y_in = 1'b1; end
                            S_T4: begin cu.c_out = 1'b1; cu.z_in = 1'b1; end
                            S_T5: begin
                                cu.z_low_out = 1'b1;
                                if (opcode == OP_LDI) begin
                                    cu.gra = 1'b1; cu.r_in = 1'b1; step_done = 1'b1;
                                end else begin
                                    cu.mar_in = 1'b1;
                                end
                            end
                            S_T6: begin
                                // store places the register on the bus while read stays low
                                if (opcode == OP_LD) begin
                                    cu.read = 1'b1; cu.mdr_in = 1'b1;
                                end else begin
                                    cu.gra = 1'b1; cu.r_out = 1'b1; cu.mdr_in = 1'b1;
                                end
                            end
                            S_T7: begin
                                step_done = 1'b1;
                                if (opcode == OP_LD) begin
                                    cu.mdr_out = 1'b1; cu.gra = 1'b1; cu.r_in = 1'b1;
                                end else begin
                                    cu.write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            S_T3: begin cu.grb = 1'b1; cu.r_out = 1'b1; cu.y_in = 1'b1; end
                            S_T4: begin
                                cu.z_in   = 1'b1;
                                cu.alu_op = alu_sel;
                                if (is_imm) cu.c_out = 1'b1;
                                else begin cu.grc = 1'b1; cu.r_out = 1'b1; end
                            end
                            default: begin
                                cu.z_low_out = 1'b1; cu.gra = 1'b1; cu.r_in = 1'b1;
                                step_done = 1'b1;
                            end
                        endcase
                    end
                    OP_OUT: begin
                        cu.gra = 1'b1; cu.r_out = 1'b1; cu.outport_in = 1'b1;
                        step_done = 1'b1;
                    end
                    default: begin
                        step_done = 1'b1;
                        to_halt   = (opcode == OP_HALT);
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST:  state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   state <= S_T2;
                S_T2:   state <= S_T3;
                S_T7:   state <= S_T0;
                S_HALT: state <= S_HALT;
                default: begin
                    if (step_done) state <= to_halt ? S_HALT : S_T0;
                    else           state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Strobe-level bench for the sequencer: an instruction-level model queues the expected
// strobe vector of every step, and a monitor compares the DUT each cycle.
module tb_control_unit;
    typedef struct packed {
        logic gra, grb, grc, r_in, r_out, ba_out, pc_in, pc_out, inc_pc, ir_in;
        logic y_in, z_in, z_low_out, c_out, mar_in, mdr_in, mdr_out, read, write, outport_in;
        logic [3:0] alu_op;
        logic run, done;
    } outs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   step_no = 0;
    outs_t exp_q[$];
    logic [3:0] rtab [8] = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0] itab [3] = '{4'd2, 4'd0, 4'd1};

    control_unit_if bus ();
    control_unit dut (.clk(clk), .reset_n(reset_n), .cu(bus));

    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t a;
        a.gra = bus.gra;   a.grb = bus.grb;       a.grc = bus.grc;
        a.r_in = bus.r_in; a.r_out = bus.r_out;   a.ba_out = bus.ba_out;
        a.pc_in = bus.pc_in; a.pc_out = bus.pc_out; a.inc_pc = bus.inc_pc;
        a.ir_in = bus.ir_in; a.y_in = bus.y_in;   a.z_in = bus.z_in;
        a.z_low_out = bus.z_low_out; a.c_out = bus.c_out; a.mar_in = bus.mar_in;
        a.mdr_in = bus.mdr_in; a.mdr_out = bus.mdr_out; a.read = bus.read;
        a.write = bus.write; a.outport_in = bus.outport_in;
        a.alu_op = bus.alu_op; a.run = bus.run; a.done = bus.done;
        return a;
    endfunction

    function automatic outs_t base();
        outs_t s = '0;
        s.alu_op = 4'd2;
        s.run = 1'b1;
        return s;
    endfunction

    function automatic outs_t rst_v();
        outs_t s = '0;
        s.run = 1'b1;
        return s;
    endfunction

    // Reference: one expected vector per step of the instruction, fetch included.
    task automatic push_instr(input logic [4:0] op, output int len);
        outs_t s;
        int n0 = exp_q.size();
        s = base(); s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.z_in = 1; exp_q.push_back(s);
        s = base(); s.z_low_out = 1; s.pc_in = 1; s.read = 1; s.mdr_in = 1; exp_q.push_back(s);
        s = base(); s.mdr_out = 1; s.ir_in = 1; exp_q.push_back(s);
        if (op <= 5'd2) begin
            s = base(); s.grb = 1; s.ba_out = 1; s.y_in = 1; exp_q.push_back(s);
            s = base(); s.c_out = 1; s.z_in = 1; exp_q.push_back(s);
            s = base(); s.z_low_out = 1;
            if (op == 5'd1) begin
                s.gra = 1; s.r_in = 1; s.done = 1; exp_q.push_back(s);
            end else begin
                s.mar_in = 1; exp_q.push_back(s);
                s = base();
                if (op == 5'd0) begin s.read = 1; s.mdr_in = 1; end
                else begin s.gra = 1; s.r_out = 1; s.mdr_in = 1; end
                exp_q.push_back(s);
                s = base();
                if (op == 5'd0) begin s.mdr_out = 1; s.gra = 1; s.r_in = 1; end
                else s.write = 1;
                s.done = 1; exp_q.push_back(s);
            end
        end else if (op <= 5'd13) begin
            s = base(); s.grb = 1; s.r_out = 1; s.y_in = 1; exp_q.push_back(s);
            s = base(); s.z_in = 1;
            if (op <= 5'd10) begin s.grc = 1; s.r_out = 1; s.alu_op = rtab[int'(op) - 3]; end
            else begin s.c_out = 1; s.alu_op = itab[int'(op) - 11]; end
            exp_q.push_back(s);
            s = base(); s.z_low_out = 1; s.gra = 1; s.r_in = 1; s.done = 1; exp_q.push_back(s);
        end else if (op == 5'd23) begin
            s = base(); s.gra = 1; s.r_out = 1; s.outport_in = 1; s.done = 1; exp_q.push_back(s);
        end else begin
            s = base(); s.done = 1; exp_q.push_back(s);
        end
        len = exp_q.size() - n0;
    endtask

    task automatic check(input string name, input outs_t got, input outs_t want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    // Called at posedge+1 while the DUT sits in T0.
    task automatic run_instr(input logic [4:0] op);
        int len;
        bus.ir = {op, 27'($urandom())};
        push_instr(op, len);
        repeat (len) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT in T0.
    task automatic do_reset(input int ncyc);
        reset_n = 1'b0;
        #1;
        check("async_reset", sample(), rst_v());
        repeat (ncyc) exp_q.push_back(rst_v());
        repeat (ncyc) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back(rst_v());
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t e;
            e = exp_q.pop_front();
            check($sformatf("step%0d", step_no), sample(), e);
            step_no++;
        end
    end

    initial begin
        int len;
        logic [4:0] op;
        bus.ir = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", sample(), rst_v());
        reset_n = 1'b1;
        exp_q.push_back(rst_v());
        @(posedge clk); #1;

        // ld interrupted by a two-cycle reset while in T5
        bus.ir = {5'd0, 27'h0400065};
        push_instr(5'd0, len);
        repeat (3) void'(exp_q.pop_back());
        repeat (5) begin @(posedge clk); #1; end
        do_reset(2);

        run_instr(5'd0);
        run_instr(5'd3);
        run_instr(5'd2);
        run_instr(5'd13);
        run_instr(5'd11);
        run_instr(5'd1);
        run_instr(5'd26);
        run_instr(5'd23);
        run_instr(5'd27);
        repeat (20) exp_q.push_back(outs_t'('0));
        repeat (20) begin @(posedge clk); #1; end
        do_reset(1);

        repeat (150) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr(op);
        end
        run_instr(5'd27);
        repeat (3) exp_q.push_back(outs_t'('0));
        repeat (4) begin @(posedge clk); #1; end

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain got=%0d want=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
